fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the instruction decoder.
- Owns the PC and issues one word request at a time to the instruction memory.
- Holds the IF/ID pipeline slot (instruction + PC + valid) that the decoder reads.
- Honours stalls from the hazard unit and PC redirects from beq/jal resolution.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the
// instruction memory.
//
// Handshake: the master raises req with a word-aligned addr; the request is
// accepted on a rising clock edge where req && gnt. Exactly one response
// follows, signalled by rvalid (with rdata) on a later edge, at least one
// cycle after the accepting edge. The master keeps at most one request
// outstanding. gnt seen while req is low has no meaning and is ignored.
//
// Signals:
//   req     master -> slave   request valid
//   addr    master -> slave   word address, bits [1:0] are zero
//   gnt     slave  -> master  request accepted this cycle
//   rvalid  slave  -> master  response data valid
//   rdata   slave  -> master  instruction word
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, issues
// one instruction-memory request at a time and fills the IF/ID slot read by
// the decoder. Honours stalls from the hazard unit and redirects from
// branch/jump resolution.
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst_n          asynchronous active-low reset
//   stall_i        hold the IF/ID slot this cycle
//   redirect_i     taken branch/jump: flush and refetch
//   redirect_pc_i  new fetch address, bits [1:0] ignored
//   imem           instruction-memory bus (master side)
//   if_inst_o      IF/ID instruction
//   if_pc_o        PC of if_inst_o
//   if_valid_o     slot holds a real instruction
//   dbg_state_o    fetch FSM state (0 REQ, 1 WAIT, 2 HOLD, 3 KILL)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_inst_o,
  output logic [31:0]          if_pc_o,
  output logic                 if_valid_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request on the bus
    ST_WAIT = 2'd1,  // request accepted, waiting for rvalid
    ST_HOLD = 2'd2,  // response parked in the skid buffer during a stall
    ST_KILL = 2'd3   // draining a response that a redirect made stale
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;

  logic        deliver;
  logic [31:0] deliver_inst;
  logic [31:0] deliver_pc;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  // Bus outputs depend only on registered state, never on inputs.
  assign imem.req    = (state_q == ST_REQ);
  assign imem.addr   = {pc_q[31:2], 2'b00};

  assign if_inst_o   = if_inst_q;
  assign if_pc_o     = if_pc_q;
  assign if_valid_o  = if_valid_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    deliver      = 1'b0;
    deliver_inst = imem.rdata;
    deliver_pc   = fetch_pc_q;

    unique case (state_q)
      ST_REQ: begin
        if (imem.gnt) begin
          state_d    = ST_WAIT;
          fetch_pc_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (imem.rvalid) begin
          if (!stall_i) begin
            deliver = 1'b1;
            pc_d    = pc_plus4;
            state_d = ST_REQ;
          end else begin
            skid_inst_d = imem.rdata;
            skid_pc_d   = fetch_pc_q;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          deliver      = 1'b1;
          deliver_inst = skid_inst_q;
          deliver_pc   = skid_pc_q;
          pc_d         = pc_plus4;
          state_d      = ST_REQ;
        end
      end
      ST_KILL: begin
        if (imem.rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase

    // A redirect overrides stall and any delivery in the same cycle. If a
    // request is (or is becoming) outstanding, its response must be drained
    // in KILL before the new address can be requested.
    if (redirect_i) begin
      deliver = 1'b0;
      pc_d    = redirect_pc_i & ~32'h3;
      unique case (state_q)
        ST_REQ:  state_d = imem.gnt    ? ST_KILL : ST_REQ;
        ST_WAIT: state_d = imem.rvalid ? ST_REQ  : ST_KILL;
        ST_HOLD: state_d = ST_REQ;
        ST_KILL: state_d = imem.rvalid ? ST_REQ  : ST_KILL;
        default: state_d = ST_REQ;
      endcase
    end

    // IF/ID slot: load on delivery, hold under stall, otherwise a bubble.
    // A bubble keeps the previous PC.
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    if (redirect_i) begin
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
    end else if (deliver) begin
      if_inst_d  = deliver_inst;
      if_pc_d    = deliver_pc;
      if_valid_d = 1'b1;
    end else if (!stall_i) begin
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= 32'h0;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= 32'h0;
      if_inst_q   <= NOP_INST;
      if_pc_q     <= 32'h0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      if_valid_q  <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Documented debug-state encoding.
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_KILL = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic        if_valid_o;
  logic [1:0]  dbg_state_o;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o),
    .if_valid_o    (if_valid_o),
    .dbg_state_o   (dbg_state_o)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard of instructions the decoder should see, in order.
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory contents: 0x3000 -> 0x24010001, 0x3004 -> 0x24020002, ...
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] idx;
    idx = ((a - 32'h3000) >> 2) + 32'd1;
    return 32'h2400_0000 | ({24'h0, idx[7:0]} << 16) | {16'h0, idx[15:0]};
  endfunction

  // ---------------- memory responder ----------------
  bit          mem_owed;
  logic [31:0] mem_addr;

  // ---------------- reference model ----------------
  // pend: 0 nothing outstanding, 1 response wanted, 2 response to discard.
  logic [31:0] m_pc, m_req_pc, m_buf_inst, m_buf_pc;
  int          m_pend;
  bit          m_buf_v;
  bit          m_slot_v;
  logic [31:0] m_slot_inst, m_slot_pc;

  task automatic model_reset();
    m_pc = RESET_PC; m_pend = 0; m_buf_v = 0; m_req_pc = 0;
    m_buf_inst = 0; m_buf_pc = 0;
    m_slot_v = 0; m_slot_inst = NOP_INST; m_slot_pc = 0;
  endtask

  function automatic bit m_req();
    return (m_pend == 0) && !m_buf_v;
  endfunction

  function automatic logic [1:0] m_state();
    if (m_buf_v) return S_HOLD;
    if (m_pend == 1) return S_WAIT;
    if (m_pend == 2) return S_KILL;
    return S_REQ;
  endfunction

  task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                            input bit g, input bit rv, input logic [31:0] rdat);
    bit granted, returned, dlv;
    logic [31:0] d_inst, d_pc;
    granted  = m_req() && g;
    returned = (m_pend != 0) && rv;
    dlv = 0; d_inst = 0; d_pc = 0;
    if (rd) begin
      m_pc = rpc & ~32'h3;
      m_buf_v = 0;
      if (granted) m_pend = 2;
      else if (returned) m_pend = 0;
      else if (m_pend != 0) m_pend = 2;
      m_slot_v = 0; m_slot_inst = NOP_INST;
    end else begin
      if (granted) begin
        m_pend = 1; m_req_pc = m_pc;
      end else if (returned) begin
        if (m_pend == 1) begin
          if (st) begin
            m_buf_v = 1; m_buf_inst = rdat; m_buf_pc = m_req_pc;
          end else begin
            dlv = 1; d_inst = rdat; d_pc = m_req_pc;
          end
        end
        m_pend = 0;
      end else if (m_buf_v && !st) begin
        dlv = 1; d_inst = m_buf_inst; d_pc = m_buf_pc; m_buf_v = 0;
      end
      if (dlv) begin
        m_slot_v = 1; m_slot_inst = d_inst; m_slot_pc = d_pc;
        m_pc = m_pc + 32'd4;
      end else if (!st) begin
        m_slot_v = 0; m_slot_inst = NOP_INST;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns 1 time unit after the next rising edge.
  task automatic apply(input bit st, input bit rd, input logic [31:0] rpc,
                       input bit g, input bit rv_en);
    bit rv;
    logic [31:0] rdat;
    rv   = rv_en && mem_owed;
    rdat = rv ? word_at(mem_addr) : $urandom;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem.gnt      = g;
    imem.rvalid   = rv;
    imem.rdata    = rdat;
    model_step(st, rd, rpc, g, rv, rdat);
    if (m_slot_v && !rd && (m_slot_pc == m_req_pc || m_slot_pc == m_buf_pc)) begin
      // nothing: scoreboard is filled from the model below
    end
    if (rv) mem_owed = 0;
    if (imem.req && g) begin
      mem_owed = 1;
      mem_addr = imem.addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = 0;
  endtask

  task automatic check_pre(input string tag);
    check({tag, " req"},  {31'h0, imem.req}, {31'h0, m_req()});
    check({tag, " addr"}, imem.addr, m_pc);
  endtask

  task automatic check_post(input string tag);
    check({tag, " valid"}, {31'h0, if_valid_o}, {31'h0, m_slot_v});
    check({tag, " inst"},  if_inst_o, m_slot_inst);
    check({tag, " pc"},    if_pc_o, m_slot_pc);
    check({tag, " state"}, {30'h0, dbg_state_o}, {30'h0, m_state()});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          st, rd;
    logic [31:0] rpc;
    bit          g, rv;
    bit          e_req;
    logic [31:0] e_addr;
    logic [1:0]  e_state;
    bit          e_valid;
    logic [31:0] e_inst, e_pc;
  } vec_t;

  function automatic vec_t mk(bit st, bit rd, logic [31:0] rpc, bit g, bit rv,
                              bit e_req, logic [31:0] e_addr, logic [1:0] e_state,
                              bit e_valid, logic [31:0] e_inst, logic [31:0] e_pc);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.g = g; v.rv = rv;
    v.e_req = e_req; v.e_addr = e_addr; v.e_state = e_state;
    v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t tab[19];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int delivered;
    // Basic fetch, prefetch under stall, redirect during WAIT, redirect with
    // rvalid and stall together, PC wrap.
    tab[0]  = mk(0,0,0,            1,0, 1,32'h3000,    S_WAIT,0,NOP_INST,    32'h0);
    tab[1]  = mk(0,0,0,            0,1, 0,32'h3000,    S_REQ, 1,32'h24010001,32'h3000);
    tab[2]  = mk(0,0,0,            1,0, 1,32'h3004,    S_WAIT,0,NOP_INST,    32'h3000);
    tab[3]  = mk(0,0,0,            0,1, 0,32'h3004,    S_REQ, 1,32'h24020002,32'h3004);
    tab[4]  = mk(1,0,0,            1,0, 1,32'h3008,    S_WAIT,1,32'h24020002,32'h3004);
    tab[5]  = mk(1,0,0,            0,1, 0,32'h3008,    S_HOLD,1,32'h24020002,32'h3004);
    tab[6]  = mk(1,0,0,            1,0, 0,32'h3008,    S_HOLD,1,32'h24020002,32'h3004);
    tab[7]  = mk(1,0,0,            1,0, 0,32'h3008,    S_HOLD,1,32'h24020002,32'h3004);
    tab[8]  = mk(0,0,0,            0,0, 0,32'h3008,    S_REQ, 1,32'h24030003,32'h3008);
    tab[9]  = mk(0,0,0,            1,0, 1,32'h300C,    S_WAIT,0,NOP_INST,    32'h3008);
    tab[10] = mk(0,1,32'h3043,     0,0, 0,32'h300C,    S_KILL,0,NOP_INST,    32'h3008);
    tab[11] = mk(0,0,0,            0,1, 0,32'h3040,    S_REQ, 0,NOP_INST,    32'h3008);
    tab[12] = mk(0,0,0,            1,0, 1,32'h3040,    S_WAIT,0,NOP_INST,    32'h3008);
    tab[13] = mk(0,0,0,            0,1, 0,32'h3040,    S_REQ, 1,32'h24110011,32'h3040);
    tab[14] = mk(1,0,0,            1,0, 1,32'h3044,    S_WAIT,1,32'h24110011,32'h3040);
    tab[15] = mk(1,1,32'hFFFFFFFF, 0,1, 0,32'h3044,    S_REQ, 0,NOP_INST,    32'h3040);
    tab[16] = mk(0,0,0,            1,0, 1,32'hFFFFFFFC,S_WAIT,0,NOP_INST,    32'h3040);
    tab[17] = mk(0,0,0,            0,1, 0,32'hFFFFFFFC,S_REQ, 1,32'h2400F400,32'hFFFFFFFC);
    tab[18] = mk(0,0,0,            0,0, 1,32'h00000000,S_REQ, 0,NOP_INST,    32'hFFFFFFFC);

    rst_n = 1'b0;
    idle_inputs();
    mem_owed = 0; mem_addr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset valid", {31'h0, if_valid_o}, 32'h0);
    check("reset inst",  if_inst_o, NOP_INST);
    check("reset pc",    if_pc_o, 32'h0);
    check("reset req",   {31'h0, imem.req}, 32'h1);
    check("reset addr",  imem.addr, RESET_PC);
    check("reset state", {30'h0, dbg_state_o}, {30'h0, S_REQ});
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 19; i++) begin
      check($sformatf("tab%0d req", i),  {31'h0, imem.req}, {31'h0, tab[i].e_req});
      check($sformatf("tab%0d addr", i), imem.addr, tab[i].e_addr);
      apply(tab[i].st, tab[i].rd, tab[i].rpc, tab[i].g, tab[i].rv);
      check($sformatf("tab%0d state", i), {30'h0, dbg_state_o}, {30'h0, tab[i].e_state});
      check($sformatf("tab%0d valid", i), {31'h0, if_valid_o}, {31'h0, tab[i].e_valid});
      check($sformatf("tab%0d inst", i),  if_inst_o, tab[i].e_inst);
      check($sformatf("tab%0d pc", i),    if_pc_o, tab[i].e_pc);
      @(negedge clk);
    end

    // Randomized traffic against the reference model. The scoreboard also
    // tracks the instruction stream the decoder accepts (valid, not stalled).
    delivered = 0;
    for (int c = 0; c < 1500; c++) begin
      bit st, rd, g, rve;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      g   = ($urandom_range(0, 1) == 1);
      rve = ($urandom_range(0, 2) != 0);
      check_pre($sformatf("rnd%0d", c));
      apply(st, rd, rpc, g, rve);
      check_post($sformatf("rnd%0d", c));
      if (m_slot_v && !st) exp_q.push_back(m_slot_inst);
      if (if_valid_o && !st) begin
        if (exp_q.size() == 0) begin
          check("stream order empty", if_inst_o, 32'hxxxx_xxxx);
        end else begin
          check("stream order", if_inst_o, exp_q.pop_front());
          delivered++;
        end
      end
      @(negedge clk);
    end
    check("stream drained", exp_q.size(), 32'h0);
    tests++;
    if (delivered < 50) begin
      fails++;
      $display("FAIL random delivery count: got %0d expected at least 50", delivered);
    end

    // Drive into WAIT, then pulse reset with the request in flight.
    idle_inputs();
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      apply(0, 0, 0, 1, (m_pend == 2));
      @(negedge clk);
      if (m_pend == 1 && !m_buf_v) ok = 1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reach WAIT: got state %0d expected %0d", dbg_state_o, S_WAIT);
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async rst valid", {31'h0, if_valid_o}, 32'h0);
    check("async rst inst",  if_inst_o, NOP_INST);
    check("async rst pc",    if_pc_o, 32'h0);
    check("async rst state", {30'h0, dbg_state_o}, {30'h0, S_REQ});
    check("async rst addr",  imem.addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    // Stale response arrives in REQ without a grant: must be ignored.
    apply(0, 0, 0, 0, 1);
    check("stale rvalid valid", {31'h0, if_valid_o}, 32'h0);
    check("stale rvalid state", {30'h0, dbg_state_o}, {30'h0, S_REQ});
    @(negedge clk);
    check("post rst addr", imem.addr, 32'h3000);
    check("post rst req",  {31'h0, imem.req}, 32'h1);
    apply(0, 0, 0, 1, 0);
    @(negedge clk);
    apply(0, 0, 0, 0, 1);
    check("post rst inst",  if_inst_o, 32'h24010001);
    check("post rst pc",    if_pc_o, 32'h3000);
    check("post rst valid", {31'h0, if_valid_o}, 32'h1);
    check_post("post rst model");
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
